// File: rtl/alu_arbiter_pkg.sv
// Shared types and ALU op encodings for the two-requester ALU arbiter.
package alu_arb_pkg;
   typedef enum logic {ST_IDLE, ST_RESP} arb_state_t;

   localparam logic ALU_ADD = 1'b0;
   localparam logic ALU_SUB = 1'b1;

   typedef logic req_id_t;
endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between issue logic, the ALU arbiter and writeback.
interface alu_arbiter_if #(parameter int DATA_WIDTH = 32);
   logic [1:0]            req_valid;
   logic [1:0]            req_ready;
   logic                  req_ctrl0;
   logic                  req_ctrl1;
   logic [DATA_WIDTH-1:0] req_op1_0;
   logic [DATA_WIDTH-1:0] req_op1_1;
   logic [DATA_WIDTH-1:0] req_op2_0;
   logic [DATA_WIDTH-1:0] req_op2_1;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic                  rsp_id;
   logic [DATA_WIDTH-1:0] rsp_data;
   logic                  rsp_eq;

   // Arbiter side
   modport slave (
      input  req_valid, req_ctrl0, req_ctrl1, req_op1_0, req_op1_1, req_op2_0, req_op2_1,
      input  rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_data, rsp_eq
   );

   // Requesters and response consumer
   modport master (
      output req_valid, req_ctrl0, req_ctrl1, req_op1_0, req_op1_1, req_op2_0, req_op2_1,
      output rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_eq
   );
endinterface

// File: rtl/alu_arbiter_alu.sv
// Combinational add/subtract with operand-equality flag.
module alu_unit
   import alu_arb_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  ctrl,
   input  logic [DATA_WIDTH-1:0] op1,
   input  logic [DATA_WIDTH-1:0] op2,
   output logic [DATA_WIDTH-1:0] res,
   output logic                  eq
);
   assign res = (ctrl == ALU_SUB) ? (op1 - op2) : (op1 + op2);
   assign eq  = (op1 == op2);
endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters, with a held response register.
// Optional grant counters are built when ALU_ARB_STATS_EN is defined.
module alu_arbiter
   import alu_arb_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int STAT_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   alu_arbiter_if.slave          bus
`ifdef ALU_ARB_STATS_EN
   ,
   output logic [STAT_WIDTH-1:0] stat_grant0,
   output logic [STAT_WIDTH-1:0] stat_grant1
`endif
);
   arb_state_t            state, state_nxt;
   req_id_t               rr_ptr, grant;
   logic [1:0]            req_ready;
   logic                  xfer;
   logic                  alu_ctrl, alu_eq;
   logic [DATA_WIDTH-1:0] alu_op1, alu_op2, alu_res;
   logic                  rsp_id, rsp_eq;
   logic [DATA_WIDTH-1:0] rsp_data;

   // Pointer's requester wins if it asks; otherwise the other one gets a turn.
   always_comb begin
      grant = rr_ptr;
      if (!bus.req_valid[rr_ptr] && bus.req_valid[~rr_ptr])
         grant = ~rr_ptr;
   end

   always_comb begin
      req_ready = 2'b00;
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (bus.req_valid[grant]) begin
               req_ready[grant] = 1'b1;
               state_nxt        = ST_RESP;
            end
         end
         ST_RESP: begin
            if (bus.rsp_ready)
               state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign xfer = |(bus.req_valid & req_ready);

   assign alu_ctrl = grant ? bus.req_ctrl1 : bus.req_ctrl0;
   assign alu_op1  = grant ? bus.req_op1_1 : bus.req_op1_0;
   assign alu_op2  = grant ? bus.req_op2_1 : bus.req_op2_0;

   alu_unit #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
      .ctrl (alu_ctrl),
      .op1  (alu_op1),
      .op2  (alu_op2),
      .res  (alu_res),
      .eq   (alu_eq)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr   <= 1'b0;
         rsp_id   <= 1'b0;
         rsp_data <= '0;
         rsp_eq   <= 1'b0;
      end else if (xfer) begin
         rr_ptr   <= ~grant;
         rsp_id   <= grant;
         rsp_data <= alu_res;
         rsp_eq   <= alu_eq;
      end
   end

`ifdef ALU_ARB_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_grant0 <= '0;
         stat_grant1 <= '0;
      end else if (xfer) begin
         if (!grant && stat_grant0 != '1) stat_grant0 <= stat_grant0 + 1'b1;
         if ( grant && stat_grant1 != '1) stat_grant1 <= stat_grant1 + 1'b1;
      end
   end
`endif

   assign bus.req_ready = req_ready;
   assign bus.rsp_valid = (state == ST_RESP);
   assign bus.rsp_id    = rsp_id;
   assign bus.rsp_data  = rsp_data;
   assign bus.rsp_eq    = rsp_eq;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter; inputs change 1ns after posedge, outputs checked there too.
module tb_alu_arbiter;
`ifdef ALU_ARB_STATS_EN
   localparam int SW = 2;
`else
   localparam int SW = 16;
`endif
   localparam int DW = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   alu_arbiter_if #(.DATA_WIDTH(DW)) bus ();

`ifdef ALU_ARB_STATS_EN
   logic [SW-1:0] stat_grant0, stat_grant1;
`endif

   alu_arbiter #(.DATA_WIDTH(DW), .STAT_WIDTH(SW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
`ifdef ALU_ARB_STATS_EN
      ,
      .stat_grant0 (stat_grant0),
      .stat_grant1 (stat_grant1)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_req0(input logic ctrl, input logic [31:0] a, input logic [31:0] b);
      bus.req_ctrl0 = ctrl; bus.req_op1_0 = a; bus.req_op2_0 = b;
   endtask

   task automatic set_req1(input logic ctrl, input logic [31:0] a, input logic [31:0] b);
      bus.req_ctrl1 = ctrl; bus.req_op1_1 = a; bus.req_op2_1 = b;
   endtask

   // Drain one response in a single cycle
   task automatic drain();
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
   endtask

   initial begin
      bus.req_valid = 2'b00;
      bus.rsp_ready = 1'b0;
      set_req0(1'b0, 32'd0, 32'd0);
      set_req1(1'b0, 32'd0, 32'd0);
      tick(); tick();

      // reset state
      chk("rst_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_data",  bus.rsp_data,       32'd0);
      chk("rst_eq",    32'(bus.rsp_eq),    32'd0);
      chk("rst_id",    32'(bus.rsp_id),    32'd0);
      chk("rst_ready", 32'(bus.req_ready), 32'd0);
      rst = 1'b0;
      tick();

      // REQ0 add 7+5 alone
      set_req0(1'b0, 32'd7, 32'd5);
      bus.req_valid = 2'b01;
      #1 chk("add_ready", 32'(bus.req_ready), 32'b01);
      tick();
      bus.req_valid = 2'b00;
      chk("add_valid", 32'(bus.rsp_valid), 32'd1);
      chk("add_data",  bus.rsp_data,       32'd12);
      chk("add_eq",    32'(bus.rsp_eq),    32'd0);
      chk("add_id",    32'(bus.rsp_id),    32'd0);
      chk("add_busy",  32'(bus.req_ready), 32'b00);
      drain();
      chk("add_done",  32'(bus.rsp_valid), 32'd0);

      // REQ1 alone (pointer now at 1): add wraps FFFFFFFF+2 -> 1
      set_req1(1'b0, 32'hFFFF_FFFF, 32'd2);
      bus.req_valid = 2'b10;
      #1 chk("wrap_ready", 32'(bus.req_ready), 32'b10);
      tick();
      bus.req_valid = 2'b00;
      chk("wrap_add", bus.rsp_data,    32'd1);
      chk("wrap_id",  32'(bus.rsp_id), 32'd1);
      drain();

      // Both valid, pointer back at 0: REQ0 9-9 first, then REQ1 3+4
      set_req0(1'b1, 32'd9, 32'd9);
      set_req1(1'b0, 32'd3, 32'd4);
      bus.req_valid = 2'b11;
      #1 chk("both_ready0", 32'(bus.req_ready), 32'b01);
      tick();
      bus.req_valid = 2'b10;
      chk("both_data0", bus.rsp_data,       32'd0);
      chk("both_eq0",   32'(bus.rsp_eq),    32'd1);
      chk("both_id0",   32'(bus.rsp_id),    32'd0);
      bus.rsp_ready = 1'b1;
      tick();
      chk("both_ready1", 32'(bus.req_ready), 32'b10);
      bus.rsp_ready = 1'b0;
      tick();
      bus.req_valid = 2'b00;
      chk("both_data1", bus.rsp_data,       32'd7);
      chk("both_id1",   32'(bus.rsp_id),    32'd1);
      chk("both_eq1",   32'(bus.rsp_eq),    32'd0);
      drain();

      // Sub wrap 0-1 on REQ0
      set_req0(1'b1, 32'd0, 32'd1);
      bus.req_valid = 2'b01;
      tick();
      bus.req_valid = 2'b00;
      chk("wrap_sub",    bus.rsp_data,    32'hFFFF_FFFF);
      chk("wrap_sub_eq", 32'(bus.rsp_eq), 32'd0);
      drain();

      // Backpressure: REQ0 1+1 held 5 cycles while REQ1 waits
      set_req0(1'b0, 32'd1, 32'd1);
      set_req1(1'b0, 32'd10, 32'd20);
      bus.req_valid = 2'b01;
      tick();
      bus.req_valid = 2'b10;
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid", 32'(bus.rsp_valid), 32'd1);
         chk("bp_data",  bus.rsp_data,       32'd2);
         chk("bp_eq",    32'(bus.rsp_eq),    32'd1);
         chk("bp_ready", 32'(bus.req_ready), 32'b00);
         tick();
      end
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
      chk("bp_release", 32'(bus.req_ready), 32'b10);
      tick();
      bus.req_valid = 2'b00;
      chk("bp_data1", bus.rsp_data,    32'd30);
      chk("bp_id1",   32'(bus.rsp_id), 32'd1);
      drain();

      // Valid dropped before an edge: nothing latched
      bus.req_valid = 2'b01;
      #1 chk("drop_ready", 32'(bus.req_ready), 32'b01);
      bus.req_valid = 2'b00;
      tick();
      chk("drop_valid", 32'(bus.rsp_valid), 32'd0);
      chk("drop_data",  bus.rsp_data,       32'd30);

      // Reset mid-RESP, pointer left at 1 beforehand
      set_req0(1'b0, 32'd100, 32'd23);
      bus.req_valid = 2'b01;
      tick();
      bus.req_valid = 2'b00;
      chk("mid_valid", 32'(bus.rsp_valid), 32'd1);
      chk("mid_data",  bus.rsp_data,       32'd123);
      #2 rst = 1'b1;
      #1 chk("mid_rst_valid", 32'(bus.rsp_valid), 32'd0);
      chk("mid_rst_data", bus.rsp_data, 32'd0);
      tick();
      rst = 1'b0;
      tick();
      bus.req_valid = 2'b11;
      #1 chk("post_rst_ready", 32'(bus.req_ready), 32'b01);
      bus.req_valid = 2'b00;
      tick();

`ifdef ALU_ARB_STATS_EN
      // Five REQ1 grants saturate a 2-bit counter at 3
      set_req1(1'b0, 32'd1, 32'd2);
      for (int i = 0; i < 5; i++) begin
         bus.req_valid = 2'b10;
         tick();
         bus.req_valid = 2'b00;
         drain();
      end
      chk("stat_grant1", 32'(stat_grant1), 32'd3);
      chk("stat_grant0", 32'(stat_grant0), 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
